// File: rtl/rx_deframer_auth.sv
// rx_deframer_auth: receive-side deframer. Splits a decrypted frame into message,
// counter and auth tag, verifies the tag, enforces a strictly increasing counter,
// and hands accepted plaintext downstream on a valid/ready handshake.
module rx_deframer_auth #(
    parameter int unsigned MSG_WIDTH         = 488,
    parameter int unsigned FRAMER_CNTR_WIDTH = 16,
    parameter int unsigned FRAMER_AUTH_WIDTH = 8,
    parameter int unsigned DROP_CNT_WIDTH    = 8
) (
    input  logic                                                          clk,
    input  logic                                                          resetN,
    input  logic                                                          valid_in,
    output logic                                                          ready_out,
    input  logic [MSG_WIDTH+FRAMER_CNTR_WIDTH+FRAMER_AUTH_WIDTH-1:0]      frame_in,
    input  logic                                                          ready_in,
    output logic                                                          valid_out,
    output logic [MSG_WIDTH-1:0]                                          plaintext_data_out,
    output logic                                                          auth_fail,
    output logic                                                          replay_fail,
    output logic [DROP_CNT_WIDTH-1:0]                                     drop_cnt
);

    localparam int unsigned FRAMED_TOTAL_WIDTH = MSG_WIDTH + FRAMER_CNTR_WIDTH + FRAMER_AUTH_WIDTH;
    localparam int unsigned N_CHUNKS           = (MSG_WIDTH + FRAMER_CNTR_WIDTH) / FRAMER_AUTH_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_OUTPUT = 2'd2,
        S_DROP   = 2'd3
    } state_t;

    state_t                          r_state;
    logic [FRAMED_TOTAL_WIDTH-1:0]   r_frame;
    logic                            r_chk_stage;
    logic                            r_auth_bad;
    logic                            r_is_replay;
    logic [FRAMER_CNTR_WIDTH-1:0]    r_last_cntr;
    logic                            r_seen;
    logic                            r_ready;
    logic                            r_valid;
    logic [MSG_WIDTH-1:0]            r_data;
    logic                            r_auth_fail;
    logic                            r_replay_fail;
    logic [DROP_CNT_WIDTH-1:0]       r_drop_cnt;

    logic [MSG_WIDTH-1:0]            w_msg;
    logic [FRAMER_CNTR_WIDTH-1:0]    w_cntr;
    logic [FRAMER_AUTH_WIDTH-1:0]    w_auth;
    logic [FRAMER_AUTH_WIDTH-1:0]    w_exp_tag;
    logic [DROP_CNT_WIDTH-1:0]       w_drop_next;

    assign w_msg  = r_frame[FRAMED_TOTAL_WIDTH-1 -: MSG_WIDTH];
    assign w_cntr = r_frame[FRAMER_AUTH_WIDTH +: FRAMER_CNTR_WIDTH];
    assign w_auth = r_frame[FRAMER_AUTH_WIDTH-1:0];

    // Saturating increment of the dropped-frame counter
    assign w_drop_next = (r_drop_cnt == {DROP_CNT_WIDTH{1'b1}}) ? r_drop_cnt
                                                                : r_drop_cnt + DROP_CNT_WIDTH'(1);

    // Expected tag: XOR of every auth-width chunk of {msg, cntr}
    always_comb begin
        w_exp_tag = '0;
        for (int i = 0; i < int'(N_CHUNKS); i++) begin
            w_exp_tag = w_exp_tag ^ r_frame[FRAMER_AUTH_WIDTH + i*FRAMER_AUTH_WIDTH +: FRAMER_AUTH_WIDTH];
        end
    end

    // Frame FSM: accept, check (tag/replay flags registered, then decide), output or drop
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_frame       <= '0;
            r_chk_stage   <= 1'b0;
            r_auth_bad    <= 1'b0;
            r_is_replay   <= 1'b0;
            r_last_cntr   <= '0;
            r_seen        <= 1'b0;
            r_ready       <= 1'b0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_auth_fail   <= 1'b0;
            r_replay_fail <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_auth_fail   <= 1'b0;
            r_replay_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in && r_ready) begin
                        r_frame     <= frame_in;
                        r_ready     <= 1'b0;
                        r_chk_stage <= 1'b0;
                        r_state     <= S_CHECK;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!r_chk_stage) begin
                        // Register the wide XOR reduction and compare before deciding
                        r_chk_stage <= 1'b1;
                        r_auth_bad  <= (w_exp_tag != w_auth);
                        r_is_replay <= r_seen && (w_cntr <= r_last_cntr);
                    end else if (r_auth_bad) begin
                        // Auth failure wins; counter history is left untouched
                        r_auth_fail <= 1'b1;
                        r_drop_cnt  <= w_drop_next;
                        r_state     <= S_DROP;
                    end else if (r_is_replay) begin
                        r_replay_fail <= 1'b1;
                        r_drop_cnt    <= w_drop_next;
                        r_state       <= S_DROP;
                    end else begin
                        r_last_cntr <= w_cntr;
                        r_seen      <= 1'b1;
                        r_data      <= w_msg;
                        r_valid     <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (ready_in) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_out          = r_ready;
    assign valid_out          = r_valid;
    assign plaintext_data_out = r_data;
    assign auth_fail          = r_auth_fail;
    assign replay_fail        = r_replay_fail;
    assign drop_cnt           = r_drop_cnt;

endmodule

// File: tb/tb_rx_deframer_auth.sv
// Bench for rx_deframer_auth: reference model predicts each frame's outcome into a
// scoreboard queue; a monitor pops and compares on handshakes and drop pulses.
module tb_rx_deframer_auth;

    localparam int unsigned MSG_W = 488;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TOT_W = 512;

    localparam logic [1:0] K_OUT    = 2'd0;
    localparam logic [1:0] K_AUTH   = 2'd1;
    localparam logic [1:0] K_REPLAY = 2'd2;

    typedef struct {
        logic [1:0]       kind;
        logic [MSG_W-1:0] data;
    } exp_t;

    logic             clk;
    logic             resetN;
    logic             valid_in;
    logic             ready_out;
    logic [TOT_W-1:0] frame_in;
    logic             ready_in;
    logic             valid_out;
    logic [MSG_W-1:0] plaintext_data_out;
    logic             auth_fail;
    logic             replay_fail;
    logic [7:0]       drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    exp_t             q[$];
    logic             m_seen;
    logic [CNT_W-1:0] m_last;
    logic [7:0]       m_drop;

    rx_deframer_auth dut (
        .clk                (clk),
        .resetN             (resetN),
        .valid_in           (valid_in),
        .ready_out          (ready_out),
        .frame_in           (frame_in),
        .ready_in           (ready_in),
        .valid_out          (valid_out),
        .plaintext_data_out (plaintext_data_out),
        .auth_fail          (auth_fail),
        .replay_fail        (replay_fail),
        .drop_cnt           (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] calc_tag(input logic [MSG_W-1:0] m, input logic [CNT_W-1:0] c);
        logic [MSG_W+CNT_W-1:0] v;
        logic [7:0]             t;
        v = {m, c};
        t = 8'h00;
        for (int i = 0; i < 63; i++) t = t ^ v[i*8 +: 8];
        return t;
    endfunction

    function automatic logic [MSG_W-1:0] rand_msg();
        logic [MSG_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[MSG_W-33:0], 32'($urandom)};
        return r;
    endfunction

    // Monitor: compare DUT output events against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (resetN === 1'b1) begin
            if (valid_out === 1'b1 && ready_in === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL out_unexpected: got data=%h, none expected", plaintext_data_out);
                end else begin
                    e = q.pop_front();
                    if (e.kind !== K_OUT || plaintext_data_out !== e.data) begin
                        n_errors++;
                        $display("FAIL out_data: got kind=out data=%h, expected kind=%0d data=%h",
                                 plaintext_data_out, e.kind, e.data);
                    end
                end
            end
            if (auth_fail === 1'b1 || replay_fail === 1'b1) begin
                n_checks++;
                if (auth_fail === 1'b1 && replay_fail === 1'b1) begin
                    n_errors++;
                    $display("FAIL pulse_both: auth_fail=1 replay_fail=1, expected only one");
                end else if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL pulse_unexpected: auth=%b replay=%b, none expected", auth_fail, replay_fail);
                end else begin
                    e = q.pop_front();
                    if ((auth_fail === 1'b1 && e.kind !== K_AUTH) ||
                        (replay_fail === 1'b1 && e.kind !== K_REPLAY)) begin
                        n_errors++;
                        $display("FAIL pulse_kind: auth=%b replay=%b, expected kind=%0d",
                                 auth_fail, replay_fail, e.kind);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        q.delete();
        m_seen = 1'b0;
        m_last = '0;
        m_drop = 8'h00;
    endtask

    task automatic predict(input logic [MSG_W-1:0] msg, input logic [CNT_W-1:0] cntr, input bit bad);
        exp_t e;
        e.data = msg;
        if (bad) begin
            e.kind = K_AUTH;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end else if (m_seen && cntr <= m_last) begin
            e.kind = K_REPLAY;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end else begin
            e.kind = K_OUT;
            m_seen = 1'b1;
            m_last = cntr;
        end
        q.push_back(e);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (ready_out !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (ready_out !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ready: ready_out=%b after %0d cycles, expected 1", ready_out, k);
        end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (valid_out !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (valid_out !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_valid: valid_out=%b after %0d cycles, expected 1", valid_out, k);
        end
    endtask

    // Drive one frame; returns just after the accepting edge
    task automatic send(input logic [MSG_W-1:0] msg, input logic [CNT_W-1:0] cntr, input bit bad);
        logic [7:0] t;
        t = calc_tag(msg, cntr) ^ (bad ? 8'h01 : 8'h00);
        wait_ready();
        predict(msg, cntr, bad);
        frame_in = {msg, cntr, t};
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic check_drop(input string name);
        n_checks++;
        if (drop_cnt !== m_drop) begin
            n_errors++;
            $display("FAIL %s: drop_cnt=%0d expected %0d", name, drop_cnt, m_drop);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (ready_out !== 1'b0 || valid_out !== 1'b0 || plaintext_data_out !== '0 ||
            auth_fail !== 1'b0 || replay_fail !== 1'b0 || drop_cnt !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h af=%b rf=%b drop=%0d expected all zero",
                     ready_out, valid_out, plaintext_data_out, auth_fail, replay_fail, drop_cnt);
        end
        resetN = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: ready_out=%b expected 1", ready_out);
        end
    endtask

    task automatic test_basic();
        logic [MSG_W-1:0] m;
        m = MSG_W'(3);
        ready_in = 1'b1;
        send(m, 16'd1, 1'b0);
        n_checks++;
        if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_accept: rdy=%b vld=%b expected 0 0", ready_out, valid_out);
        end
        @(posedge clk); #1;
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_lat1: valid_out=%b expected 0", valid_out);
        end
        @(posedge clk); #1;
        n_checks++;
        if (valid_out !== 1'b1 || plaintext_data_out !== m) begin
            n_errors++;
            $display("FAIL basic_lat2: vld=%b data=%h expected 1 %h", valid_out, plaintext_data_out, m);
        end
        wait_ready();
    endtask

    task automatic test_backpressure();
        logic [MSG_W-1:0] m;
        m = rand_msg();
        ready_in = 1'b0;
        send(m, 16'd2, 1'b0);
        wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid_out !== 1'b1 || plaintext_data_out !== m || ready_out !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_%0d: vld=%b rdy=%b data=%h expected 1 0 %h",
                         i, valid_out, ready_out, plaintext_data_out, m);
            end
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_release: vld=%b rdy=%b expected 0 1", valid_out, ready_out);
        end
    endtask

    task automatic test_auth();
        ready_in = 1'b1;
        send(MSG_W'(3), 16'd3, 1'b1);
        wait_ready();
        check_drop("auth_drop_cnt");
        send(MSG_W'(3), 16'd3, 1'b0);
        wait_ready();
        check_drop("auth_then_ok_drop_cnt");
    endtask

    task automatic test_replay();
        ready_in = 1'b1;
        send(rand_msg(), 16'd5, 1'b0); wait_ready();
        send(rand_msg(), 16'd5, 1'b0); wait_ready();
        send(rand_msg(), 16'd4, 1'b0); wait_ready();
        check_drop("replay_drop_cnt");
        send(rand_msg(), 16'd6, 1'b0); wait_ready();
        check_drop("replay_after_ok_drop_cnt");
    endtask

    task automatic test_reset_mid();
        ready_in = 1'b0;
        send(rand_msg(), 16'd7, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        resetN = 1'b0;
        @(posedge clk); #1;
        model_reset();
        n_checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b0 || drop_cnt !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid: vld=%b rdy=%b drop=%0d expected 0 0 0", valid_out, ready_out, drop_cnt);
        end
        resetN = 1'b1;
        ready_in = 1'b1;
        send(rand_msg(), 16'd1, 1'b0);
        wait_ready();
        check_drop("reset_mid_drop_cnt");
    endtask

    task automatic test_wrap_saturate();
        ready_in = 1'b1;
        send(rand_msg(), 16'hFFFF, 1'b0); wait_ready();
        send(rand_msg(), 16'h0000, 1'b0); wait_ready();
        check_drop("wrap_drop_cnt");
        for (int i = 0; i < 256; i++) begin
            send(rand_msg(), 16'($urandom), 1'b1);
        end
        wait_ready();
        check_drop("saturate_drop_cnt");
        n_checks++;
        if (drop_cnt !== 8'hFF) begin
            n_errors++;
            $display("FAIL saturate_ff: drop_cnt=%h expected ff", drop_cnt);
        end
    endtask

    initial begin
        valid_in = 1'b0;
        ready_in = 1'b1;
        frame_in = '0;
        resetN   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_auth();
        test_replay();
        test_reset_mid();
        test_wrap_saturate();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
